// File: rtl/mxint8_pkg.sv
// Shared constants, types and FSM encoding for the MXINT8 block collector.
package mxint8_pkg;

    localparam int BLOCK_SIZE  = 32;
    localparam int ELEM_WIDTH  = 8;
    localparam int SCALE_WIDTH = 8;
    localparam int CNT_WIDTH   = $clog2(BLOCK_SIZE);

    typedef logic [ELEM_WIDTH-1:0] mxint8_elem_t;
    typedef mxint8_elem_t mxint8_block_t [BLOCK_SIZE-1:0];

    typedef enum logic [1:0] {
        S_SCALE,
        S_ELEM,
        S_FULL,
        S_DRAIN
    } collector_state_t;

endpackage

// File: rtl/mxint8_block_collector.sv
// Collects a byte-serial MXINT8 stream (scale beat followed by BLOCK_SIZE
// element beats) into a parallel block for the block-sum stage, flagging and
// resynchronising on framing errors signalled through the last-beat flag.
module mxint8_block_collector
    import mxint8_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [ELEM_WIDTH-1:0]  i_data,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [SCALE_WIDTH-1:0] o_scale,
    output logic [ELEM_WIDTH-1:0]  o_mxint8_elements [BLOCK_SIZE-1:0],
    output logic                   o_err
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BLOCK_SIZE - 1);

    collector_state_t      state_q;
    collector_state_t      state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic                  err_d;
    logic                  ready_q;
    logic                  valid_q;
    logic                  err_q;
    logic                  beat;
    logic                  block_xfer;

    // Handshakes are qualified by the registered ready/valid flags only.
    assign beat       = i_valid && ready_q;
    assign block_xfer = valid_q && i_ready;

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;

    // Framing FSM: decides the next state, counter and error event per beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_SCALE: begin
                if (beat) begin
                    if (i_last) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_ELEM;
                        cnt_d   = '0;
                    end
                end
            end
            S_ELEM: begin
                if (beat) begin
                    if (cnt_q == LAST_IDX) begin
                        if (i_last) begin
                            state_d = S_FULL;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end else if (i_last) begin
                        err_d   = 1'b1;
                        state_d = S_SCALE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (block_xfer) begin
                    state_d = S_SCALE;
                end
            end
            S_DRAIN: begin
                if (beat && i_last) begin
                    state_d = S_SCALE;
                end
            end
            default: begin
                state_d = S_SCALE;
            end
        endcase
    end

    // State, counter and registered handshake/error flags; ready stays low in
    // reset and rises on the first clock after it so nothing is taken early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_SCALE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d != S_FULL);
            valid_q <= (state_d == S_FULL);
            err_q   <= err_d;
        end
    end

    // Raw capture of the scale and element beats; nothing is written in S_FULL,
    // so the presented block stays stable until the sum stage takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_scale <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                o_mxint8_elements[i] <= '0;
            end
        end else begin
            if (state_q == S_SCALE && beat) begin
                o_scale <= i_data[SCALE_WIDTH-1:0];
            end
            if (state_q == S_ELEM && beat) begin
                o_mxint8_elements[cnt_q] <= i_data;
            end
        end
    end

endmodule
